// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//   Registered up/down counter that presents its index both in binary and in
//   standard reflected Gray code. Typical use is generating read/write pointers
//   for clock-domain-crossing FIFOs, where the Gray output must change at most
//   one bit per count step.
//
//   Parameters
//     DATA_WIDTH  counter width (>= 2); the count wraps modulo 2**DATA_WIDTH
//
//   Ports
//     clk       rising-edge clock for all state
//     resetn    asynchronous active-low reset; clears bin_out, gray_out, wrap
//     en        count enable, one step per cycle while high
//     dir       1 = count up, 0 = count down (only looked at when en is high)
//     load      synchronous load of load_bin; takes priority over en
//     load_bin  binary index to load
//     bin_out   current index, binary, registered
//     gray_out  current index, Gray coded, registered
//     wrap      one-cycle registered pulse when the count rolls over
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  wrap
);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("gray_counter: DATA_WIDTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0] bin_reg;
  logic [DATA_WIDTH-1:0] bin_next;
  logic [DATA_WIDTH-1:0] gray_reg;
  logic [DATA_WIDTH-1:0] gray_next;
  logic                  wrap_reg;
  logic                  wrap_next;

  // Next-state selection: load beats en, en beats hold. A rollover is
  // detected from the current value so wrap lines up with the wrapped output.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (dir) begin
        bin_next  = bin_reg + DATA_WIDTH'(1);
        wrap_next = (bin_reg == {DATA_WIDTH{1'b1}});
      end else begin
        bin_next  = bin_reg - DATA_WIDTH'(1);
        wrap_next = (bin_reg == {DATA_WIDTH{1'b0}});
      end
    end
  end

  // Gray is encoded from the next binary value and registered alongside it,
  // so gray_out comes straight off a flop and never glitches through logic.
  for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_gray_enc
    assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
  end
  assign gray_next[DATA_WIDTH-1] = bin_next[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bin_out  = bin_reg;
  assign gray_out = gray_reg;
  assign wrap     = wrap_reg;

endmodule
